full_adder: RTL and testbench
=============================

Name: full_adder

Overview:
- Single-cycle binary adder, operands `a`, `b` plus carry-in `cin`.
- Produces `sum`/`cout` combinationally (zero latency) and a registered copy one clock later.
- Optional saturating count of carry-out events.
- Leaf arithmetic cell, used standalone or as a ripple slice in wider datapaths.

Parameters:
- WIDTH, 1, operand width in bits; legal range 1..64.
- CNT_W, 16, width of carry-event counter; legal range 1..32.

Ports:
- clk  input  1  rising-edge clock; the only clock
- rst  input  1  synchronous, active-high reset
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry in
- in_valid  input  1  qualifies a/b/cin for register capture
- sum  output  WIDTH  combinational sum bits
- cout  output  1  combinational carry out
- sum_q  output  WIDTH  registered sum
- cout_q  output  1  registered carry out
- out_valid  output  1  sum_q/cout_q hold a fresh result this cycle
- carry_cnt  output  CNT_W  saturating count of captured results with carry out = 1

Behaviour:
- Combinational path:
  - {cout, sum} = a + b + cin, computed at WIDTH+1 bits; no truncation before the carry.
  - sum is the low WIDTH bits; cout is bit WIDTH.
  - Purely combinational; no dependence on clk, rst or in_valid.
  - Outputs are valid within the same evaluation as an input change.
- WIDTH=1 truth table (a b cin -> sum cout):
  - 000->0 0; 001->1 0; 010->1 0; 011->0 1
  - 100->1 0; 101->0 1; 110->0 1; 111->1 1
- Registered path, on each rising clk:
  - rst=1: sum_q=0, cout_q=0, out_valid=0, carry_cnt=0. Reset dominates in_valid.
  - rst=0, in_valid=1: sum_q<=sum, cout_q<=cout, out_valid<=1.
  - rst=0, in_valid=0: sum_q/cout_q hold their value, out_valid<=0.
  - Latency is exactly 1 cycle from in_valid sampled high to out_valid high with the matching result.
  - Back-to-back in_valid gives one result per cycle; no backpressure.
- carry_cnt:
  - Increments by 1 on each clock where rst=0, in_valid=1 and cout=1.
  - Saturates at 2^CNT_W-1 and never wraps.
  - Cleared only by rst.
- Reset mid-stream: a capture in the reset cycle is discarded; out_valid=0 the following cycle.
- Inputs containing X/Z: no requirement on combinational outputs. Registered outputs are only required to be correct for known inputs.

Optional Feature:
- Macro FULL_ADDER_CARRY_CNT_EN.
- Defined: carry_cnt counter is implemented as specified above.
- Undefined:
  - No counter flops are synthesized.
  - carry_cnt is driven constant 0.
  - Port list is unchanged.
  - All other behaviour is identical.

Test Plan:
- Exhaustive WIDTH=1: apply the 8 combinations 000..111, 10 time units each, check sum/cout. Example: 011 -> sum=0, cout=1; 111 -> sum=1, cout=1.
- Registered latency: rst for 2 cycles, then in_valid=1 with a=1, b=1, cin=0 for one cycle. Next cycle: out_valid=1, sum_q=0, cout_q=1. Following cycle, with in_valid=0: out_valid=0 and sum_q/cout_q hold.
- Reset priority: rst=1 and in_valid=1 with 111 in the same cycle -> next cycle sum_q=0, cout_q=0, out_valid=0, carry_cnt=0.
- Carry counting (macro defined): 5 valid cycles of 101 -> carry_cnt=5. Interleaved 001 with in_valid=1, and 111 with in_valid=0, do not increment.
- Saturation: CNT_W=2, 6 valid carry-producing cycles -> carry_cnt stays at 3. Macro undefined: carry_cnt=0 throughout.
- WIDTH=8 boundary: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.

Source files
------------

// File: rtl/full_adder.sv
// WIDTH-bit adder with carry-in: combinational sum/cout plus a registered copy one clock later.
// Define FULL_ADDER_CARRY_CNT_EN to build the saturating carry-out event counter (carry_cnt).
module full_adder #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             in_valid,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic [WIDTH-1:0] sum_q,
    output logic             cout_q,
    output logic             out_valid,
    output logic [CNT_W-1:0] carry_cnt
);

    // Widen before adding so the carry out of the top bit is never lost.
    logic [WIDTH:0] total;
    assign total = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(cin);
    assign sum   = total[WIDTH-1:0];
    assign cout  = total[WIDTH];

    logic [WIDTH-1:0] sum_d;
    logic             cout_d;
    logic             out_valid_d;
    logic             out_valid_q;

    always_comb begin
        sum_d       = sum_q;
        cout_d      = cout_q;
        out_valid_d = 1'b0;
        if (in_valid) begin
            sum_d       = sum;
            cout_d      = cout;
            out_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q       <= '0;
            cout_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;

`ifdef FULL_ADDER_CARRY_CNT_EN
    logic [CNT_W-1:0] carry_cnt_d;
    logic [CNT_W-1:0] carry_cnt_q;

    // Stick at all-ones rather than wrapping back to zero.
    always_comb begin
        carry_cnt_d = carry_cnt_q;
        if (in_valid && cout && (carry_cnt_q != {CNT_W{1'b1}})) begin
            carry_cnt_d = carry_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            carry_cnt_q <= '0;
        end else begin
            carry_cnt_q <= carry_cnt_d;
        end
    end

    assign carry_cnt = carry_cnt_q;
`else
    assign carry_cnt = '0;
`endif

endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench for full_adder: a WIDTH=1 instance and a WIDTH=8/CNT_W=2 instance
// checked against an integer-arithmetic reference model.
module tb_full_adder;

    localparam int CNT1_MAX = 65535;
    localparam int CNT8_MAX = 3;
`ifdef FULL_ADDER_CARRY_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // WIDTH=1 instance
    logic        a1 = 0, b1 = 0, cin1 = 0, v1 = 0;
    logic        sum1, cout1, sum_q1, cout_q1, ov1;
    logic [15:0] cnt1;
    // WIDTH=8, CNT_W=2 instance
    logic [7:0]  a8 = 0, b8 = 0;
    logic        cin8 = 0, v8 = 0;
    logic [7:0]  sum8, sum_q8;
    logic        cout8, cout_q8, ov8;
    logic [1:0]  cnt8;

    full_adder #(.WIDTH(1), .CNT_W(16)) u_w1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .cin(cin1), .in_valid(v1),
        .sum(sum1), .cout(cout1), .sum_q(sum_q1), .cout_q(cout_q1),
        .out_valid(ov1), .carry_cnt(cnt1)
    );

    full_adder #(.WIDTH(8), .CNT_W(2)) u_w8 (
        .clk(clk), .rst(rst), .a(a8), .b(b8), .cin(cin8), .in_valid(v8),
        .sum(sum8), .cout(cout8), .sum_q(sum_q8), .cout_q(cout_q8),
        .out_valid(ov8), .carry_cnt(cnt8)
    );

    int nchecks = 0;
    int nerrors = 0;

    // Reference model: results expressed as plain integer sums.
    int m1_sum = 0, m1_cout = 0, m1_vld = 0, m1_cnt = 0;
    int m8_sum = 0, m8_cout = 0, m8_vld = 0, m8_cnt = 0;

    always @(posedge clk) begin
        int t;
        if (rst) begin
            m1_sum = 0; m1_cout = 0; m1_vld = 0; m1_cnt = 0;
            m8_sum = 0; m8_cout = 0; m8_vld = 0; m8_cnt = 0;
        end else begin
            m1_vld = int'(v1);
            if (v1) begin
                t = int'(a1) + int'(b1) + int'(cin1);
                m1_sum = t % 2; m1_cout = t / 2;
                if (m1_cout == 1 && m1_cnt < CNT1_MAX) m1_cnt++;
            end
            m8_vld = int'(v8);
            if (v8) begin
                t = int'(a8) + int'(b8) + int'(cin8);
                m8_sum = t % 256; m8_cout = t / 256;
                if (m8_cout == 1 && m8_cnt < CNT8_MAX) m8_cnt++;
            end
        end
    end

    function automatic int exp_cnt(input int c);
        return CNT_EN ? c : 0;
    endfunction

    task automatic drive1(input logic a, input logic b, input logic c, input logic v);
        @(negedge clk);
        a1 = a; b1 = b; cin1 = c; v1 = v;
    endtask

    task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic c, input logic v);
        @(negedge clk);
        a8 = a; b8 = b; cin8 = c; v8 = v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; v1 = 0; v8 = 0;
        tick(); tick();
        nchecks++;
        if (sum_q1 !== 1'b0 || cout_q1 !== 1'b0 || ov1 !== 1'b0 || cnt1 !== 16'd0) begin
            nerrors++;
            $display("FAIL reset_w1: got sum_q=%0d cout_q=%0d ov=%0d cnt=%0d, want all 0", sum_q1, cout_q1, ov1, cnt1);
        end
        nchecks++;
        if (sum_q8 !== 8'h00 || cout_q8 !== 1'b0 || ov8 !== 1'b0 || cnt8 !== 2'd0) begin
            nerrors++;
            $display("FAIL reset_w8: got sum_q=%0h cout_q=%0d ov=%0d cnt=%0d, want all 0", sum_q8, cout_q8, ov8, cnt8);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_exhaustive_w1();
        for (int i = 0; i < 8; i++) begin
            logic [2:0] p;
            int t;
            p = 3'(i);
            a1 = p[2]; b1 = p[1]; cin1 = p[0]; v1 = 0;
            #10;
            t = int'(p[2]) + int'(p[1]) + int'(p[0]);
            $display("txn comb w1 a=%0d b=%0d cin=%0d -> sum=%0d cout=%0d", p[2], p[1], p[0], sum1, cout1);
            nchecks++;
            if (int'(sum1) !== t % 2 || int'(cout1) !== t / 2) begin
                nerrors++;
                $display("FAIL truth_%0d%0d%0d: got sum=%0d cout=%0d, want sum=%0d cout=%0d",
                         p[2], p[1], p[0], sum1, cout1, t % 2, t / 2);
            end
        end
    endtask

    task automatic test_latency();
        rst = 1'b1;
        tick(); tick();
        drive1(1, 1, 0, 1);
        rst = 1'b0;
        tick();
        $display("txn latency capture 1+1+0 -> ov=%0d sum_q=%0d cout_q=%0d", ov1, sum_q1, cout_q1);
        nchecks++;
        if (ov1 !== 1'b1 || sum_q1 !== 1'b0 || cout_q1 !== 1'b1) begin
            nerrors++;
            $display("FAIL latency_capture: got ov=%0d sum_q=%0d cout_q=%0d, want ov=1 sum_q=0 cout_q=1", ov1, sum_q1, cout_q1);
        end
        drive1(0, 0, 1, 0);
        tick();
        nchecks++;
        if (ov1 !== 1'b0 || sum_q1 !== 1'b0 || cout_q1 !== 1'b1) begin
            nerrors++;
            $display("FAIL latency_hold: got ov=%0d sum_q=%0d cout_q=%0d, want ov=0 sum_q=0 cout_q=1", ov1, sum_q1, cout_q1);
        end
    endtask

    task automatic test_reset_priority();
        drive1(1, 1, 1, 1);
        rst = 1'b1;
        tick();
        nchecks++;
        if (ov1 !== 1'b0 || sum_q1 !== 1'b0 || cout_q1 !== 1'b0 || cnt1 !== 16'd0) begin
            nerrors++;
            $display("FAIL reset_priority: got ov=%0d sum_q=%0d cout_q=%0d cnt=%0d, want all 0", ov1, sum_q1, cout_q1, cnt1);
        end
        drive1(0, 0, 0, 0);
        rst = 1'b0;
        tick();
        nchecks++;
        if (ov1 !== 1'b0) begin
            nerrors++;
            $display("FAIL reset_discard: got ov=%0d, want 0", ov1);
        end
    endtask

    task automatic test_carry_count();
        for (int i = 0; i < 5; i++) begin
            drive1(1, 0, 1, 1);
            tick();
            drive1(0, 0, 1, 1);
            tick();
            drive1(1, 1, 1, 0);
            tick();
        end
        $display("txn carry_count -> cnt=%0d", cnt1);
        nchecks++;
        if (int'(cnt1) !== exp_cnt(5) || int'(cnt1) !== exp_cnt(m1_cnt)) begin
            nerrors++;
            $display("FAIL carry_count: got %0d, want %0d", cnt1, exp_cnt(5));
        end
    endtask

    task automatic test_w8_boundary();
        drive8(8'hFF, 8'h01, 0, 1);
        #1;
        nchecks++;
        if (sum8 !== 8'h00 || cout8 !== 1'b1) begin
            nerrors++;
            $display("FAIL w8_ff_01: got sum=%0h cout=%0d, want sum=00 cout=1", sum8, cout8);
        end
        drive8(8'hFF, 8'hFF, 1, 1);
        #1;
        nchecks++;
        if (sum8 !== 8'hFF || cout8 !== 1'b1) begin
            nerrors++;
            $display("FAIL w8_ff_ff_1: got sum=%0h cout=%0d, want sum=ff cout=1", sum8, cout8);
        end
        tick();
        nchecks++;
        if (ov8 !== 1'b1 || sum_q8 !== 8'hFF || cout_q8 !== 1'b1) begin
            nerrors++;
            $display("FAIL w8_registered: got ov=%0d sum_q=%0h cout_q=%0d, want ov=1 sum_q=ff cout_q=1", ov8, sum_q8, cout_q8);
        end
    endtask

    task automatic test_saturation();
        rst = 1'b1;
        drive8(0, 0, 0, 0);
        tick();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive8(8'hFF, 8'h01, 0, 1);
            tick();
            $display("txn saturation step %0d -> cnt=%0d", i, cnt8);
            nchecks++;
            if (int'(cnt8) !== exp_cnt((i + 1 > 3) ? 3 : i + 1)) begin
                nerrors++;
                $display("FAIL saturation_%0d: got %0d, want %0d", i, cnt8, exp_cnt((i + 1 > 3) ? 3 : i + 1));
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            logic [7:0] ra, rb;
            logic rc, rv;
            int t;
            ra = 8'($urandom); rb = 8'($urandom);
            rc = 1'($urandom); rv = ($urandom_range(0, 3) != 0);
            drive8(ra, rb, rc, rv);
            #1;
            t = int'(ra) + int'(rb) + int'(rc);
            nchecks++;
            if (int'(sum8) !== t % 256 || int'(cout8) !== t / 256) begin
                nerrors++;
                $display("FAIL rand_comb_%0d: got sum=%0h cout=%0d, want sum=%0h cout=%0d", i, sum8, cout8, t % 256, t / 256);
            end
            tick();
            $display("txn rand %0d a=%02h b=%02h cin=%0d v=%0d -> ov=%0d sum_q=%02h cout_q=%0d cnt=%0d",
                     i, ra, rb, rc, rv, ov8, sum_q8, cout_q8, cnt8);
            nchecks++;
            if (int'(ov8) !== m8_vld || int'(sum_q8) !== m8_sum || int'(cout_q8) !== m8_cout || int'(cnt8) !== exp_cnt(m8_cnt)) begin
                nerrors++;
                $display("FAIL rand_reg_%0d: got ov=%0d sum_q=%0h cout_q=%0d cnt=%0d, want ov=%0d sum_q=%0h cout_q=%0d cnt=%0d",
                         i, ov8, sum_q8, cout_q8, cnt8, m8_vld, m8_sum, m8_cout, exp_cnt(m8_cnt));
            end
        end
    endtask

    initial begin
        test_reset();
        test_exhaustive_w1();
        test_latency();
        test_reset_priority();
        test_carry_count();
        test_w8_boundary();
        test_saturation();
        test_random();
        $display("Result: errors=%0d of %0d checks", nerrors, nchecks);
        $finish;
    end

endmodule
